// File: rtl/round_robin_sel4.sv
// Four-channel round-robin arbiter with a registered binary grant index.
// A grant is held until the owner pulses done, drops its request, or the
// hold counter reaches MAX_HOLD (forced release, flagged by timeout).
// Every grant is separated from the next by at least one idle cycle.
module round_robin_sel4 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] W,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Count value seen on the final cycle of a full-length grant.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] r_state;
  logic [1:0] r_w;
  logic       r_gnt_valid;
  logic       r_timeout;
  logic [7:0] r_hold;
  logic [1:0] r_last;

  logic [1:0] w_sel;
  logic       w_any_req;
  logic       w_at_limit;
  logic       w_owner_req;
  logic       w_release;
  logic       w_forced;

  // First requesting channel searching upward from last+1, wrapping 3 -> 0.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = 2'(last + 2'(k));
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Next-grant selection and release decode.
  always_comb begin
    w_any_req   = |req;
    w_sel       = rr_pick(req, r_last);
    w_at_limit  = (r_hold == HOLD_LAST);
    w_owner_req = req[r_w];
    w_release   = done | ~w_owner_req | w_at_limit;
    // A limit hit coinciding with a normal release is not a timeout.
    w_forced    = w_at_limit & ~done & w_owner_req;
  end

  // Arbitration FSM with registered outputs; reset forces channel 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_w         <= 2'b00;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold      <= 8'd0;
      r_last      <= 2'd3;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timeout <= 1'b0;
          if (w_any_req) begin
            r_w         <= w_sel;
            r_gnt_valid <= 1'b1;
            r_hold      <= 8'd0;
            r_state     <= ST_GRANT;
          end else begin
            r_gnt_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_gnt_valid <= 1'b0;
            r_timeout   <= w_forced;
            r_last      <= r_w;
            r_state     <= ST_IDLE;
          end else begin
            r_hold      <= r_hold + 8'd1;
            r_timeout   <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt_valid <= 1'b0;
          r_timeout   <= 1'b0;
        end
      endcase
    end
  end

  assign W         = r_w;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
